// File: rtl/adc_frame_packer.sv
// Packs one 8-channel AD7606 sample set into an 11-word frame
// (header, seq, ch1..ch8, checksum) on a valid/ready stream.
module adc_frame_packer (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [15:0] adc_ch1_data_in,
    input  logic [15:0] adc_ch2_data_in,
    input  logic [15:0] adc_ch3_data_in,
    input  logic [15:0] adc_ch4_data_in,
    input  logic [15:0] adc_ch5_data_in,
    input  logic [15:0] adc_ch6_data_in,
    input  logic [15:0] adc_ch7_data_in,
    input  logic [15:0] adc_ch8_data_in,
    input  logic        adc_read_done,
    output logic [15:0] pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_sof,
    output logic        pkt_eof,
    output logic        busy,
    output logic [15:0] overrun_cnt
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned LAST_IDX = 10;
    localparam logic [DATA_W-1:0] HEADER_WORD = 16'hA55A;
    localparam logic [DATA_W-1:0] CNT_MAX     = 16'hFFFF;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] sample_buf [NUM_CH];
    logic [DATA_W-1:0] buf_n      [NUM_CH];
    logic [DATA_W-1:0] adc_in     [NUM_CH];
    logic [DATA_W-1:0] seq, seq_n;
    logic [DATA_W-1:0] overrun_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n, sof_n, eof_n, busy_n;

    logic [DATA_W-1:0] chk_c;
    logic [IDX_W-1:0]  nxt_idx_c;
    logic [DATA_W-1:0] nxt_word_c;
    logic              hs_c, last_c;

    assign adc_in[0] = adc_ch1_data_in;
    assign adc_in[1] = adc_ch2_data_in;
    assign adc_in[2] = adc_ch3_data_in;
    assign adc_in[3] = adc_ch4_data_in;
    assign adc_in[4] = adc_ch5_data_in;
    assign adc_in[5] = adc_ch6_data_in;
    assign adc_in[6] = adc_ch7_data_in;
    assign adc_in[7] = adc_ch8_data_in;

    assign hs_c   = pkt_valid && pkt_ready;
    assign last_c = (idx == IDX_W'(LAST_IDX));

    // Checksum covers seq and the eight channels; buffer and seq are frozen during a frame.
    always_comb begin
        chk_c = seq;
        for (int i = 0; i < NUM_CH; i++) begin
            chk_c = chk_c + sample_buf[i];
        end
    end

    // Word that follows the one currently presented.
    always_comb begin
        nxt_idx_c  = idx + IDX_W'(1);
        nxt_word_c = '0;
        if (nxt_idx_c == IDX_W'(1)) begin
            nxt_word_c = seq;
        end else if (nxt_idx_c == IDX_W'(LAST_IDX)) begin
            nxt_word_c = chk_c;
        end else if (nxt_idx_c >= IDX_W'(2) && nxt_idx_c <= IDX_W'(9)) begin
            nxt_word_c = sample_buf[CH_W'(nxt_idx_c - IDX_W'(2))];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            seq         <= '0;
            overrun_cnt <= '0;
            pkt_data    <= '0;
            pkt_valid   <= 1'b0;
            pkt_sof     <= 1'b0;
            pkt_eof     <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sample_buf[i] <= '0;
            end
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            seq         <= seq_n;
            overrun_cnt <= overrun_n;
            pkt_data    <= data_n;
            pkt_valid   <= valid_n;
            pkt_sof     <= sof_n;
            pkt_eof     <= eof_n;
            busy        <= busy_n;
            sample_buf  <= buf_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        buf_n     = sample_buf;
        seq_n     = seq;
        overrun_n = overrun_cnt;
        data_n    = pkt_data;
        valid_n   = pkt_valid;
        sof_n     = pkt_sof;
        eof_n     = pkt_eof;
        busy_n    = busy;

        case (state)
            IDLE: begin
                if (adc_read_done) begin
                    buf_n   = adc_in;
                    state_n = SEND;
                    idx_n   = '0;
                    data_n  = HEADER_WORD;
                    valid_n = 1'b1;
                    sof_n   = 1'b1;
                    eof_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            SEND: begin
                if (hs_c && last_c) begin
                    seq_n = seq + DATA_W'(1);
                    idx_n = '0;
                    eof_n = 1'b0;
                    if (adc_read_done) begin
                        // Back-to-back: new set rides straight into the next frame.
                        buf_n  = adc_in;
                        data_n = HEADER_WORD;
                        sof_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        data_n  = '0;
                        valid_n = 1'b0;
                        sof_n   = 1'b0;
                        busy_n  = 1'b0;
                    end
                end else begin
                    if (hs_c) begin
                        idx_n  = nxt_idx_c;
                        data_n = nxt_word_c;
                        sof_n  = 1'b0;
                        eof_n  = (nxt_idx_c == IDX_W'(LAST_IDX));
                    end
                    if (adc_read_done && overrun_cnt != CNT_MAX) begin
                        overrun_n = overrun_cnt + DATA_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Downstream stage of the AD7606 acquisition module. It captures one 8-channel sample set on each `adc_read_done` pulse and serialises it into an 11-word, 16-bit frame on a valid/ready stream toward the transmission FIFO/CSI path. The frame carries a header, a sequence number and a checksum. Sample sets that arrive while a frame is still being sent are dropped and counted.

## Interface
- `HEADER_WORD`, 16'hA55A, constant first word of every frame

- `sys_clk` input 1: single clock for all logic
- `rst_n` input 1: reset, asynchronous and active-low
- `adc_ch1_data_in` … `adc_ch8_data_in` input 16 each: channel V1..V8 data, valid in the cycle `adc_read_done` is high
- `adc_read_done` input 1: one-cycle pulse meaning a new sample set is present
- `pkt_data` output 16: current frame word
- `pkt_valid` output 1: `pkt_data` is valid
- `pkt_ready` input 1: sink accepts the word when `pkt_valid && pkt_ready`
- `pkt_sof` output 1: high with word 0 of a frame (qualified by `pkt_valid`)
- `pkt_eof` output 1: high with word 10 of a frame (qualified by `pkt_valid`)
- `busy` output 1: a frame is being emitted
- `overrun_cnt` output 16: count of dropped sample sets, saturates at 16'hFFFF

## Operation
- FSM states are `IDLE` and `SEND`. Word index `idx` is 0..10.
- In `IDLE`, `adc_read_done` does the following:
  - latches all 8 channel inputs into an internal buffer;
  - sets `idx = 0`;
  - moves to `SEND`.
- Frame word order:
  - word 0: `HEADER_WORD`
  - word 1: `seq`
  - words 2..9: ch1..ch8
  - word 10: `chk`
- `chk` is the 16-bit sum, modulo 2^16, of words 1..9. The header is excluded. Carries are discarded.
- `seq` is 16 bits, 0 after reset. It increments by 1 on the eof handshake and wraps from 16'hFFFF to 16'h0000.
- In `SEND`, each handshake (`pkt_valid && pkt_ready`) advances `idx`. The handshake on `idx == 10` ends the frame.
- At end of frame:
  - if `adc_read_done` is high in the same cycle, the new set is captured and the next frame starts immediately, staying in `SEND` with `idx = 0`;
  - otherwise the FSM goes to `IDLE`.
- `adc_read_done` in `SEND` in any cycle other than the eof handshake:
  - the set is dropped and the buffer is unchanged;
  - `overrun_cnt` increments unless it is already 16'hFFFF.
- `pkt_data` and the other stream outputs stay stable while `pkt_valid && !pkt_ready`.
- Reset values:
  - `pkt_valid`, `pkt_sof`, `pkt_eof`, `busy` = 0
  - `pkt_data` = 0
  - `overrun_cnt` = 0
  - `seq` = 0
  - buffer = 0
  - state = `IDLE`
- Reset asserted mid-frame abandons the partial frame. No eof is emitted and `seq` returns to 0.

## Timing
- `adc_read_done` is sampled at edge N. `pkt_valid` is high with word 0 (`pkt_sof = 1`) from cycle N+1.
- With `pkt_ready` held high, words are emitted one per cycle: frame spans N+1..N+11 and `pkt_eof` is high in cycle N+11.
- All outputs are registered. No combinational path from `pkt_ready` to `pkt_data`.
- `pkt_valid` is only allowed to drop after an eof handshake, never mid-frame.
- `busy` equals `state == SEND`. It is high from N+1 through the eof handshake cycle.
- Back-to-back case: eof handshake at cycle M together with `adc_read_done` gives word 0 of the next frame at M+1. `pkt_valid` stays high continuously.
- Minimum sample period with no drops is 11 cycles at full `pkt_ready`. At 20 kSPS and 100 MHz there are 5000 cycles per sample.

## Test plan
- **Single frame, `pkt_ready = 1`.** Stimulus: ch1..ch8 = 1..8, one `adc_read_done`. Required stream: A55A, 0000, 0001..0008, 0024. `pkt_sof` on word 0 and `pkt_eof` on word 10, both qualified by `pkt_valid`. `busy` falls after eof.
- **Backpressure.** Stimulus: same frame with `pkt_ready` toggled at random. Required: identical word sequence, `pkt_data` stable while stalled, no extra or missing words.
- **Sequence wrap.** Stimulus: send 65537 frames with ch = 0, or force `seq = 16'hFFFF`. Required: `seq` field goes FFFF then 0000. Checksum of the all-zero frame carrying seq FFFF is FFFF.
- **Overrun.** Stimulus: a second `adc_read_done` at idx 5 while `pkt_ready = 1`. Required: the first frame completes unchanged, no second frame, `overrun_cnt = 1`. A further 65535 overruns hold `overrun_cnt` at FFFF.
- **Back-to-back.** Stimulus: `adc_read_done` coincident with the eof handshake, with new data 0x8000 on all channels. Required: next frame header in the following cycle, `pkt_valid` never low, `seq` incremented. Checksum = (seq + 8×0x8000) mod 2^16 = seq.
- **Reset mid-frame.** Stimulus: assert `rst_n = 0` at idx 4. Required: all outputs 0 immediately. After release, the next frame has `seq = 0000` and `overrun_cnt = 0`.
